// File: rtl/seq_div_unit_pkg.sv
// Shared EX-stage encodings for the divider and ALU.
// Operation, FSM state and width defaults live here.
package seq_div_unit_pkg;

    localparam int DIV_N = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    localparam logic [3:0] ALU_SEL_ADD = 4'd0;
    localparam logic [3:0] ALU_SEL_SUB = 4'd1;
    localparam logic [3:0] ALU_SEL_DIV = 4'd8;

endpackage

// File: rtl/seq_div_unit_div_step.sv
// One radix-2 restoring iteration on {rem, quot}.
// Subtraction is N+1 bits wide so large unsigned divisors work.
import seq_div_unit_pkg::*;

module seq_div_unit_div_step #(
    parameter int N = DIV_N
) (
    input  logic [N-1:0] rem_i,
    input  logic [N-1:0] quot_i,
    input  logic [N-1:0] dvsr_i,
    output logic [N-1:0] rem_o,
    output logic [N-1:0] quot_o
);

    logic [N:0] shifted;
    logic [N:0] trial;

    always_comb begin
        shifted = {rem_i, quot_i[N-1]};
        trial   = shifted - {1'b0, dvsr_i};
        rem_o   = shifted[N-1:0];
        quot_o  = {quot_i[N-2:0], 1'b0};
        if (!trial[N]) begin
            rem_o     = trial[N-1:0];
            quot_o[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring divider with a
// single-cycle path for divide-by-zero and signed overflow.
import seq_div_unit_pkg::*;

module seq_div_unit #(
    parameter int N     = DIV_N,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         div_by_zero_flag,
    output logic         overflow_flag
);

    div_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] quot_q, quot_d;
    logic [N-1:0] dvsr_q, dvsr_d;
    logic [1:0] op_q, op_d;
    logic qsign_q, qsign_d;
    logic rsign_q, rsign_d;
    logic [N-1:0] result_q, result_d;
    logic dbz_q, dbz_d;
    logic ovf_q, ovf_d;

    logic [N-1:0] step_rem, step_quot;
    logic [N-1:0] quot_fix, rem_fix;
    logic [N-1:0] a_mag, b_mag;
    logic signed_op, b_zero, ovf_case;

    seq_div_unit_div_step #(.N(N)) u_step (
        .rem_i  (rem_q),
        .quot_i (quot_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quot_o (step_quot)
    );

    always_comb begin
        signed_op = ~op[0];
        a_mag     = (signed_op && A[N-1]) ? -A : A;
        b_mag     = (signed_op && B[N-1]) ? -B : B;
        b_zero    = (B == '0);
        ovf_case  = signed_op
                  && (A == {1'b1, {(N-1){1'b0}}})
                  && (B == '1);
        quot_fix  = (qsign_q && !op_q[0]) ? -step_quot : step_quot;
        rem_fix   = (rsign_q && !op_q[0]) ? -step_rem : step_rem;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        op_d     = op_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (state_q == S_RUN) begin
            rem_d  = step_rem;
            quot_d = step_quot;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
                state_d  = S_DONE;
                cnt_d    = '0;
                result_d = op_q[1] ? rem_fix : quot_fix;
                dbz_d    = 1'b0;
                ovf_d    = 1'b0;
            end
        end else begin
            state_d = S_IDLE;
            if (start) begin
                op_d    = op;
                dvsr_d  = b_mag;
                qsign_d = A[N-1] ^ B[N-1];
                rsign_d = A[N-1];
                cnt_d   = '0;
                unique case (1'b1)
                    b_zero: begin
                        state_d  = S_DONE;
                        result_d = op[1] ? A : '1;
                        dbz_d    = 1'b1;
                        ovf_d    = 1'b0;
                    end
                    ovf_case: begin
                        state_d  = S_DONE;
                        result_d = op[1] ? '0 : A;
                        dbz_d    = 1'b0;
                        ovf_d    = 1'b1;
                    end
                    default: begin
                        state_d = S_RUN;
                        rem_d   = '0;
                        quot_d  = a_mag;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            op_q     <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            op_q     <= op_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy             = (state_q == S_RUN);
    assign done             = (state_q == S_DONE);
    assign result           = result_q;
    assign div_by_zero_flag = dbz_q;
    assign overflow_flag    = ovf_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Bench for seq_div_unit: directed RV32M corner cases plus random
// operations checked against an arithmetic reference model.
module tb_seq_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero_flag;
    logic        overflow_flag;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] last_res;

    seq_div_unit dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .op               (op),
        .A                (A),
        .B                (B),
        .flush            (flush),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .div_by_zero_flag (div_by_zero_flag),
        .overflow_flag    (overflow_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(
        input logic [1:0] o, input logic [31:0] a, input logic [31:0] b
    );
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : a;
        if (o[0]) return o[1] ? a % b : a / b;
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic bit ref_dbz(input logic [31:0] b);
        return b == 0;
    endfunction

    function automatic bit ref_ovf(
        input logic [1:0] o, input logic [31:0] a, input logic [31:0] b
    );
        return !o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Drives one request; reports done latency (0 = timeout) and busy count.
    task automatic issue_op(
        input bit now, input logic [1:0] o,
        input logic [31:0] a, input logic [31:0] b,
        output int lat, output int busy_n
    );
        if (!now) @(negedge clk);
        start = 1'b1;
        op = o;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        op = 2'($urandom);
        lat = 0;
        busy_n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        A = 32'h0;
        B = 32'h0;
        #12;
        vectors++;
        if ({busy, done, result, div_by_zero_flag, overflow_flag} !== 36'h0) begin
            errors++;
            $display("FAIL reset_state got %h want 0",
                     {busy, done, result, div_by_zero_flag, overflow_flag});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [10];
        logic [31:0] t_a  [10];
        logic [31:0] t_b  [10];
        logic [31:0] t_r  [10];
        int          t_l  [10];
        logic [1:0]  t_f  [10];
        int lat, bn;
        t_op = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00,
                 2'b11, 2'b00, 2'b10, 2'b01, 2'b01};
        t_a  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5,
                 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                 32'hFFFF_FFFF};
        t_b  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0,
                 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                 32'hFFFF_FFFF};
        t_r  = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'd5, 32'h8000_0000, 32'h0, 32'd1, 32'd1};
        t_l  = '{33, 33, 33, 33, 1, 1, 1, 1, 33, 33};
        t_f  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10,
                 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 10; i++) begin
            issue_op(1'b0, t_op[i], t_a[i], t_b[i], lat, bn);
            vectors++;
            if (lat !== t_l[i]) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want %0d", i, lat, t_l[i]);
            end
            vectors++;
            if (bn !== t_l[i] - 1) begin
                errors++;
                $display("FAIL dir%0d_busy got %0d want %0d", i, bn, t_l[i] - 1);
            end
            vectors++;
            if (result !== t_r[i]) begin
                errors++;
                $display("FAIL dir%0d_result got %h want %h", i, result, t_r[i]);
            end
            vectors++;
            if ({div_by_zero_flag, overflow_flag} !== t_f[i]) begin
                errors++;
                $display("FAIL dir%0d_flags got %b want %b", i,
                         {div_by_zero_flag, overflow_flag}, t_f[i]);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_done_width got %b want 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b, er;
        int lat, bn, el;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: b = 32'hFFFF_FFFF;
                4: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            er = ref_res(o, a, b);
            el = (ref_dbz(b) || ref_ovf(o, a, b)) ? 1 : 33;
            issue_op(1'b0, o, a, b, lat, bn);
            vectors++;
            if (lat !== el || result !== er) begin
                errors++;
                $display("FAIL rand%0d op=%b a=%h b=%h got %h@%0d want %h@%0d",
                         i, o, a, b, result, lat, er, el);
            end
            vectors++;
            if ({div_by_zero_flag, overflow_flag} !==
                {ref_dbz(b), ref_ovf(o, a, b)}) begin
                errors++;
                $display("FAIL rand%0d_flags got %b want %b", i,
                         {div_by_zero_flag, overflow_flag},
                         {ref_dbz(b), ref_ovf(o, a, b)});
            end
            last_res = er;
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        issue_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h8000_0000, lat, bn);
        vectors++;
        if (lat !== 33 || result !== 32'd1) begin
            errors++;
            $display("FAIL b2b_first got %h@%0d want 1@33", result, lat);
        end
        issue_op(1'b1, 2'b01, 32'd9, 32'd3, lat, bn);
        vectors++;
        if (lat !== 33 || bn !== 32 || result !== 32'd3) begin
            errors++;
            $display("FAIL b2b_second got %h@%0d busy=%0d want 3@33 busy=32",
                     result, lat, bn);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_width got %b want 0", done);
        end
        last_res = 32'd3;
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        A = 32'd1000;
        B = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got busy=%b done=%b want 0 0", busy, done);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        vectors++;
        if (seen !== 0 || result !== last_res) begin
            errors++;
            $display("FAIL flush_hold got done=%0d res=%h want 0 %h",
                     seen, result, last_res);
        end
        start = 1'b1;
        flush = 1'b1;
        op = 2'b01;
        A = 32'd50;
        B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== last_res) begin
            errors++;
            $display("FAIL flush_priority got busy=%b done=%b res=%h want 0 0 %h",
                     busy, done, result, last_res);
        end
    endtask

    task automatic test_async_reset();
        int lat, bn;
        @(negedge clk);
        start = 1'b1;
        op = 2'b00;
        A = 32'd77;
        B = 32'd0;
        @(negedge clk);
        op = 2'b01;
        B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, result, div_by_zero_flag, overflow_flag} !== 36'h0) begin
            errors++;
            $display("FAIL async_reset got %h want 0",
                     {busy, done, result, div_by_zero_flag, overflow_flag});
        end
        @(negedge clk);
        rst = 1'b0;
        issue_op(1'b0, 2'b10, 32'hFFFF_FF9C, 32'd7, lat, bn);
        vectors++;
        if (lat !== 33 || result !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL post_reset got %h@%0d want fffffffe@33", result, lat);
        end
    endtask

    initial begin
        last_res = 32'h0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
